// File: rtl/uidbufr_interconnect.sv
// uidbufr_interconnect
//   Four-to-one FDMA read-channel arbiter (ui_clk domain). Up to four uidbuf
//   read engines share one FDMA read port. One requester is granted per burst;
//   the busy and data strobes of that burst are returned only to the winner.
//
//   Build option: define UIDBUFR_RR_ARB_EN for round-robin arbitration
//   (search starts at a priority pointer, wraps ch4 -> ch1). Undefined gives
//   fixed priority ch1 > ch2 > ch3 > ch4.
//
// Ports
//   ui_clk, ui_rstn            clock, asynchronous active-low reset
//   fdma_raddr_n/rareq_n/rsize_n   requester n burst request (n = 1..4)
//   fdma_rbusy_n/rdata_n/rvalid_n  return path to requester n
//   fdma_raddr/rareq/rsize     request to the FDMA controller
//   fdma_rbusy/rdata/rvalid    response from the FDMA controller
//   grant_ch                   current or last granted channel (0 = ch1)
module uidbufr_interconnect #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 23
) (
    input  logic                      ui_clk,
    input  logic                      ui_rstn,

    input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_1,
    input  logic                      fdma_rareq_1,
    input  logic [15:0]               fdma_rsize_1,
    output logic                      fdma_rbusy_1,
    output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_1,
    output logic                      fdma_rvalid_1,

    input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_2,
    input  logic                      fdma_rareq_2,
    input  logic [15:0]               fdma_rsize_2,
    output logic                      fdma_rbusy_2,
    output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_2,
    output logic                      fdma_rvalid_2,

    input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_3,
    input  logic                      fdma_rareq_3,
    input  logic [15:0]               fdma_rsize_3,
    output logic                      fdma_rbusy_3,
    output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_3,
    output logic                      fdma_rvalid_3,

    input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_4,
    input  logic                      fdma_rareq_4,
    input  logic [15:0]               fdma_rsize_4,
    output logic                      fdma_rbusy_4,
    output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_4,
    output logic                      fdma_rvalid_4,

    output logic [AXI_ADDR_WIDTH-1:0] fdma_raddr,
    output logic                      fdma_rareq,
    output logic [15:0]               fdma_rsize,
    input  logic                      fdma_rbusy,
    input  logic [AXI_DATA_WIDTH-1:0] fdma_rdata,
    input  logic                      fdma_rvalid,

    output logic [1:0]                grant_ch
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t                    state;
    logic [3:0]                req_vec;
    logic [1:0]                win;
    logic                      found;
    logic [AXI_ADDR_WIDTH-1:0] sel_addr;
    logic [15:0]               sel_size;
    logic                      active;

    assign req_vec = {fdma_rareq_4, fdma_rareq_3, fdma_rareq_2, fdma_rareq_1};

`ifdef UIDBUFR_RR_ARB_EN
    logic [1:0] ptr;
    logic [1:0] idx;

    // First requester at or after the pointer, wrapping ch4 -> ch1.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req_vec[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end
`else
    // Lowest-numbered requester wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!found && req_vec[2'(i)]) begin
                found = 1'b1;
                win   = 2'(i);
            end
        end
    end
`endif

    always_comb begin
        sel_addr = fdma_raddr_1;
        sel_size = fdma_rsize_1;
        case (win)
            2'd1: begin
                sel_addr = fdma_raddr_2;
                sel_size = fdma_rsize_2;
            end
            2'd2: begin
                sel_addr = fdma_raddr_3;
                sel_size = fdma_rsize_3;
            end
            2'd3: begin
                sel_addr = fdma_raddr_4;
                sel_size = fdma_rsize_4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn) begin
            state      <= IDLE;
            grant_ch   <= '0;
            fdma_rareq <= 1'b0;
            fdma_raddr <= '0;
            fdma_rsize <= '0;
`ifdef UIDBUFR_RR_ARB_EN
            ptr        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_ch   <= win;
                        fdma_raddr <= sel_addr;
                        fdma_rsize <= sel_size;
                        fdma_rareq <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (fdma_rbusy) begin
                        fdma_rareq <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (!fdma_rbusy) begin
`ifdef UIDBUFR_RR_ARB_EN
                        ptr <= grant_ch + 2'd1;
`endif
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Return path is purely combinational; gating on state keeps stray
    // controller strobes seen in IDLE away from every requester.
    assign active = (state != IDLE);

    assign fdma_rbusy_1  = fdma_rbusy  & active & (grant_ch == 2'd0);
    assign fdma_rbusy_2  = fdma_rbusy  & active & (grant_ch == 2'd1);
    assign fdma_rbusy_3  = fdma_rbusy  & active & (grant_ch == 2'd2);
    assign fdma_rbusy_4  = fdma_rbusy  & active & (grant_ch == 2'd3);
    assign fdma_rvalid_1 = fdma_rvalid & active & (grant_ch == 2'd0);
    assign fdma_rvalid_2 = fdma_rvalid & active & (grant_ch == 2'd1);
    assign fdma_rvalid_3 = fdma_rvalid & active & (grant_ch == 2'd2);
    assign fdma_rvalid_4 = fdma_rvalid & active & (grant_ch == 2'd3);

    assign fdma_rdata_1 = fdma_rdata;
    assign fdma_rdata_2 = fdma_rdata;
    assign fdma_rdata_3 = fdma_rdata;
    assign fdma_rdata_4 = fdma_rdata;

endmodule

// File: doc/uidbufr_interconnect.md
# uidbufr_interconnect

Four-to-one FDMA read-channel arbiter in the `ui_clk` domain. It lets up to four `uidbuf` read engines share the single FDMA read port of the SDRAM controller. The block grants one requester per burst and routes that burst's handshake and data back to the winner only. It is the read-side counterpart of the write interconnect that merges the four splicer write channels, and enables multi-window readback such as picture-in-picture or per-quadrant scaling.

## Interface
Parameters:
- AXI_DATA_WIDTH, 32, FDMA data width
- AXI_ADDR_WIDTH, 23, FDMA address width

Ports (n = 1..4, one identical group per requester):
- ui_clk  input  1  sole clock
- ui_rstn  input  1  reset, asynchronous, active-low
- fdma_raddr_n  input  AXI_ADDR_WIDTH  requester n burst start address
- fdma_rareq_n  input  1  requester n burst request, level
- fdma_rsize_n  input  16  requester n burst length in beats
- fdma_rbusy_n  output  1  busy returned to requester n
- fdma_rdata_n  output  AXI_DATA_WIDTH  read data to requester n
- fdma_rvalid_n  output  1  data strobe to requester n
- fdma_raddr  output  AXI_ADDR_WIDTH  address to FDMA controller
- fdma_rareq  output  1  request to FDMA controller
- fdma_rsize  output  16  burst length to FDMA controller
- fdma_rbusy  input  1  controller busy for the current burst
- fdma_rdata  input  AXI_DATA_WIDTH  controller read data
- fdma_rvalid  input  1  controller data strobe
- grant_ch  output  2  index of the current or last granted channel (0 = ch1), for debug

## Operation
- FDMA read protocol:
  - A requester raises `rareq` with a stable `raddr` and `rsize`.
  - It holds them until it sees `rbusy` high, then drops `rareq`.
  - It treats `rbusy` falling as burst done.
- State machine `IDLE -> REQ -> BUSY -> IDLE`:
  - IDLE: if any `fdma_rareq_n` is high, pick the winner, register its index into `grant_ch` and its addr/size into `fdma_raddr`/`fdma_rsize`, assert `fdma_rareq`, and go to REQ.
  - REQ: hold `fdma_rareq`, addr and size. When `fdma_rbusy` is 1, clear `fdma_rareq` and go to BUSY.
  - BUSY: when `fdma_rbusy` is 0, advance the priority pointer to `grant_ch + 1` mod 4 and go to IDLE.
- Return path:
  - `fdma_rbusy_n = fdma_rbusy & (grant_ch == n-1) & (state != IDLE)`.
  - `fdma_rvalid_n = fdma_rvalid & (grant_ch == n-1) & (state != IDLE)`.
  - `fdma_rdata_n = fdma_rdata`, broadcast to all requesters, combinational.
- Non-granted requesters see `rbusy` = 0 and `rvalid` = 0. Their requests stay pending with no time limit.
- A requester that drops `rareq` before it is granted is simply not selected. Once a channel is granted, its burst runs to completion even if its `rareq` drops.
- `fdma_rvalid` is ignored while in IDLE.
- `fdma_rsize` is passed through unmodified, including 0. Length checking is the controller's job.

## Timing
- Reset values:
  - state IDLE; priority pointer at ch1; `grant_ch` = 0.
  - `fdma_rareq` = 0, `fdma_raddr` = 0, `fdma_rsize` = 0.
  - All `fdma_rbusy_n` and `fdma_rvalid_n` = 0.
- Grant latency: `fdma_rareq` goes high 1 cycle after the winning `fdma_rareq_n` is sampled high in IDLE.
- `fdma_rareq` falls in the cycle after `fdma_rbusy` is sampled high.
- Return path adds zero cycles: `rbusy_n`, `rvalid_n` and `rdata_n` are combinational from the controller inputs.
- Turnaround: at least 1 IDLE cycle between `fdma_rbusy` falling and the next `fdma_rareq` rising. The minimum burst-to-burst gap is 2 cycles.
- If reset is asserted mid-burst, all outputs clear asynchronously. The controller must be reset by the same `ui_rstn`.
- Simultaneous requests in IDLE are resolved in the same cycle. No request is ever lost.

## Configuration
- `UIDBUFR_RR_ARB_EN` defined: round-robin arbitration.
  - Search starts at the priority pointer and wraps 4 -> 1.
  - Any continuously requesting channel is granted within 4 bursts.
- `UIDBUFR_RR_ARB_EN` undefined: fixed priority, ch1 > ch2 > ch3 > ch4.
  - The pointer logic is removed.
  - A lower channel can starve while a higher one keeps requesting.

## Test plan
- Single request: ch2 requests addr 0x000400, size 256; controller asserts busy 3 cycles after `fdma_rareq` and strobes 256 beats -> `fdma_raddr` = 0x000400, `fdma_rsize` = 256, `grant_ch` = 1, `fdma_rvalid_2` pulses 256 times, all other `rvalid_n` stay 0.
- Simultaneous requests: ch1..ch4 all request from reset, each held continuously -> with RR enabled the grant order is 1, 2, 3, 4, 1; with RR undefined ch1 is granted every burst.
- Back-to-back bursts: ch3 re-requests 1 cycle after its busy falls -> exactly 2 cycles from `fdma_rbusy` falling to the next `fdma_rareq` rising.
- Isolation: `fdma_rvalid` pulses while the controller is in IDLE, and while ch1 is granted and ch4 is requesting -> `fdma_rvalid_4` and `fdma_rbusy_4` stay 0 throughout.
- Withdrawn request: ch3 drops `rareq` after 1 cycle while ch1 holds the bus -> ch3 is never granted and the next grant goes to the next pending channel.
- Reset mid-burst: `ui_rstn` goes low during beat 100 of 256 -> all outputs are 0 immediately; after release, a new ch4 request is granted with the pointer back at ch1.
